// File: rtl/dispatch_pipe_pkg.sv
// Shared constants for the dispatch stage: MIPS opcode/funct values, issue-queue
// channel indices, FSM state encoding and the branch-target helper.
package dispatch_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;

  localparam logic [1:0] EQ_LS    = 2'd0;
  localparam logic [1:0] EQ_INT   = 2'd1;
  localparam logic [1:0] EQ_MULT  = 2'd2;
  localparam logic [1:0] EQ_DIV   = 2'd3;

  typedef enum logic [0:0] {
    StDispatch,
    StBrStall
  } disp_state_e;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/dispatch_decode.sv
// Combinational decode of the instruction held in the dispatch decode register:
// issue channel, tag/RST needs, destination register and control-flow class.
module dispatch_decode
  import dispatch_pipe_pkg::*;
#(
  parameter int unsigned W_ADDR = 5
) (
  input  logic [31:0]       inst_i,
  output logic              valid_o,
  output logic              needs_tag_o,
  output logic              writes_rst_o,
  output logic              is_branch_o,
  output logic              is_jump_o,
  output logic              is_lw_o,
  output logic [1:0]        ch_o,
  output logic [W_ADDR-1:0] dest_o,
  output logic [5:0]        opcode_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_shamt;

  assign op           = inst_i[31:26];
  assign funct        = inst_i[5:0];
  assign unused_shamt = ^inst_i[10:6];

  always_comb begin
    valid_o      = 1'b0;
    needs_tag_o  = 1'b0;
    writes_rst_o = 1'b0;
    is_branch_o  = 1'b0;
    is_jump_o    = 1'b0;
    is_lw_o      = 1'b0;
    ch_o         = EQ_INT;
    dest_o       = '0;
    opcode_o     = op;
    unique case (op)
      OP_RTYPE: begin
        valid_o      = 1'b1;
        needs_tag_o  = 1'b1;
        writes_rst_o = 1'b1;
        dest_o       = W_ADDR'(inst_i[15:11]);
        opcode_o     = funct;
        if (funct == FN_MULT)     ch_o = EQ_MULT;
        else if (funct == FN_DIV) ch_o = EQ_DIV;
        else                      ch_o = EQ_INT;
      end
      OP_BEQ, OP_BNE: begin
        valid_o     = 1'b1;
        needs_tag_o = 1'b1;
        is_branch_o = 1'b1;
        ch_o        = EQ_INT;
      end
      OP_LW: begin
        valid_o      = 1'b1;
        needs_tag_o  = 1'b1;
        writes_rst_o = 1'b1;
        is_lw_o      = 1'b1;
        dest_o       = W_ADDR'(inst_i[20:16]);
        ch_o         = EQ_LS;
      end
      OP_SW: begin
        valid_o     = 1'b1;
        needs_tag_o = 1'b1;
        ch_o        = EQ_LS;
      end
      OP_J: begin
        valid_o   = 1'b1;
        is_jump_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dispatch_pipe.sv
// Tomasulo dispatch stage with a one-entry decode register and a tag-matched branch stall.
// Optional performance counters are built when DISPATCH_PERF_CNT_EN is defined.
module dispatch_pipe
  import dispatch_pipe_pkg::*;
#(
  parameter int unsigned W_TAG  = 6,
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_ADDR = 5,
  parameter int unsigned N_EQ   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ifq_inst,
  input  logic [31:0]       ifq_pcout_plus4,
  input  logic              ifq_empty,
  output logic              ifq_ren,
  output logic              ifq_branch_valid,
  output logic [31:0]       ifq_branch_addr,
  input  logic              cdb_valid,
  input  logic [W_TAG-1:0]  cdb_tag,
  input  logic [W_DATA-1:0] cdb_data,
  input  logic              cdb_branch,
  input  logic              cdb_branch_taken,
  output logic              tag_ren,
  input  logic [W_TAG-1:0]  tag_in,
  input  logic              tag_empty,
  output logic [W_ADDR-1:0] rf_rsaddr,
  output logic [W_ADDR-1:0] rf_rtaddr,
  input  logic [W_DATA-1:0] rf_rsdata,
  input  logic [W_DATA-1:0] rf_rtdata,
  output logic [W_ADDR-1:0] rst_rsaddr,
  output logic [W_ADDR-1:0] rst_rtaddr,
  input  logic [W_TAG-1:0]  rst_rstag,
  input  logic [W_TAG-1:0]  rst_rttag,
  input  logic              rst_rspend,
  input  logic              rst_rtpend,
  output logic              rst_wen,
  output logic [W_ADDR-1:0] rst_waddr,
  output logic [W_TAG-1:0]  rst_wtag,
  output logic [N_EQ-1:0]   eq_en,
  input  logic [N_EQ-1:0]   eq_ready,
  output logic [5:0]        eq_opcode,
  output logic [15:0]       eq_imm,
  output logic [W_TAG-1:0]  eq_rdtag,
  output logic [W_TAG-1:0]  eq_rstag,
  output logic [W_TAG-1:0]  eq_rttag,
  output logic [W_DATA-1:0] eq_rsdata,
  output logic [W_DATA-1:0] eq_rtdata,
  output logic              eq_rsvalid,
  output logic              eq_rtvalid,
  output logic [31:0]       perf_dispatched,
  output logic [31:0]       perf_stalls
);

  disp_state_e      state_q, state_d;
  logic             dv_q, dv_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [W_TAG-1:0] br_tag_q, br_tag_d;
  logic [31:0]      br_target_q, br_target_d;

  logic              dec_valid, dec_needs_tag, dec_writes_rst;
  logic              dec_is_branch, dec_is_jump, dec_is_lw;
  logic [1:0]        dec_ch;
  logic [W_ADDR-1:0] dec_dest;
  logic [5:0]        dec_opcode;

  logic in_dispatch, fire, jump_now, drop, br_hit, br_taken;
  logic rs_fwd, rt_fwd;

  dispatch_decode #(
    .W_ADDR(W_ADDR)
  ) u_decode (
    .inst_i      (inst_q),
    .valid_o     (dec_valid),
    .needs_tag_o (dec_needs_tag),
    .writes_rst_o(dec_writes_rst),
    .is_branch_o (dec_is_branch),
    .is_jump_o   (dec_is_jump),
    .is_lw_o     (dec_is_lw),
    .ch_o        (dec_ch),
    .dest_o      (dec_dest),
    .opcode_o    (dec_opcode)
  );

  // Every control term is gated by reset so all strobes are low while it is held.
  always_comb begin
    in_dispatch = !reset && (state_q == StDispatch);
    fire        = in_dispatch && dv_q && dec_needs_tag && eq_ready[dec_ch] && !tag_empty;
    jump_now    = in_dispatch && dv_q && dec_is_jump;
    drop        = in_dispatch && dv_q && !dec_valid;
    br_hit      = !reset && (state_q == StBrStall) && cdb_valid && cdb_branch &&
                  (cdb_tag == br_tag_q);
    br_taken    = br_hit && cdb_branch_taken;
    ifq_ren     = in_dispatch && !ifq_empty && (!dv_q || fire) && !jump_now;
  end

  always_comb begin
    state_d     = state_q;
    dv_d        = dv_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    br_tag_d    = br_tag_q;
    br_target_d = br_target_q;
    if (fire || jump_now || drop || br_taken) dv_d = 1'b0;
    if (ifq_ren) begin
      dv_d   = 1'b1;
      inst_d = ifq_inst;
      pc4_d  = ifq_pcout_plus4;
    end
    if (fire && dec_is_branch) begin
      state_d     = StBrStall;
      br_tag_d    = tag_in;
      br_target_d = branch_target(pc4_q, inst_q[15:0]);
    end
    if (br_hit) state_d = StDispatch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StDispatch;
      dv_q        <= 1'b0;
      inst_q      <= '0;
      pc4_q       <= '0;
      br_tag_q    <= '0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      dv_q        <= dv_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      br_tag_q    <= br_tag_d;
      br_target_q <= br_target_d;
    end
  end

  always_comb begin
    ifq_branch_valid = jump_now || br_taken;
    if (jump_now)      ifq_branch_addr = {pc4_q[31:28], inst_q[25:0], 2'b00};
    else if (br_taken) ifq_branch_addr = br_target_q;
    else               ifq_branch_addr = '0;
  end

  always_comb begin
    eq_en         = '0;
    eq_en[dec_ch] = fire;
    tag_ren       = fire;
    eq_rdtag      = tag_in;
    eq_opcode     = dec_opcode;
    eq_imm        = inst_q[15:0];
    rst_wen       = fire && dec_writes_rst && (dec_dest != '0);
    rst_waddr     = dec_dest;
    rst_wtag      = tag_in;
  end

  // Operand capture: a same-cycle CDB broadcast of the pending tag supplies the value.
  always_comb begin
    rf_rsaddr  = W_ADDR'(inst_q[25:21]);
    rf_rtaddr  = W_ADDR'(inst_q[20:16]);
    rst_rsaddr = W_ADDR'(inst_q[25:21]);
    rst_rtaddr = W_ADDR'(inst_q[20:16]);
    rs_fwd     = cdb_valid && (cdb_tag == rst_rstag);
    rt_fwd     = cdb_valid && (cdb_tag == rst_rttag);
    eq_rstag   = rst_rstag;
    eq_rttag   = rst_rttag;
    eq_rsvalid = !rst_rspend || rs_fwd;
    eq_rtvalid = dec_is_lw || !rst_rtpend || rt_fwd;
    eq_rsdata  = rs_fwd ? cdb_data : rf_rsdata;
    eq_rtdata  = rt_fwd ? cdb_data : rf_rtdata;
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_disp_q, perf_disp_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_disp_d  = perf_disp_q + {31'd0, fire};
    perf_stall_d = perf_stall_q + {31'd0, dv_q && !fire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_disp_q  <= perf_disp_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_dispatched = perf_disp_q;
  assign perf_stalls     = perf_stall_q;
`else
  assign perf_dispatched = '0;
  assign perf_stalls     = '0;
`endif

endmodule

// File: tb/tb_dispatch_pipe.sv
// Self-checking bench for dispatch_pipe: directed scenarios plus a randomized run
// scored against a transaction-level model of the decode register and issue order.
module tb_dispatch_pipe;

  localparam int unsigned W_TAG  = 6;
  localparam int unsigned W_DATA = 32;
  localparam int unsigned W_ADDR = 5;
  localparam int unsigned N_EQ   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       ifq_inst, ifq_pcout_plus4;
  logic              ifq_empty, ifq_ren, ifq_branch_valid;
  logic [31:0]       ifq_branch_addr;
  logic              cdb_valid, cdb_branch, cdb_branch_taken;
  logic [W_TAG-1:0]  cdb_tag;
  logic [W_DATA-1:0] cdb_data;
  logic              tag_ren, tag_empty;
  logic [W_TAG-1:0]  tag_in;
  logic [W_ADDR-1:0] rf_rsaddr, rf_rtaddr, rst_rsaddr, rst_rtaddr, rst_waddr;
  logic [W_DATA-1:0] rf_rsdata, rf_rtdata;
  logic [W_TAG-1:0]  rst_rstag, rst_rttag, rst_wtag;
  logic              rst_rspend, rst_rtpend, rst_wen;
  logic [N_EQ-1:0]   eq_en, eq_ready;
  logic [5:0]        eq_opcode;
  logic [15:0]       eq_imm;
  logic [W_TAG-1:0]  eq_rdtag, eq_rstag, eq_rttag;
  logic [W_DATA-1:0] eq_rsdata, eq_rtdata;
  logic              eq_rsvalid, eq_rtvalid;
  logic [31:0]       perf_dispatched, perf_stalls;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [5:0]  opc;
    logic        wr;
    logic [4:0]  dest;
    logic        lw;
    logic [15:0] imm;
  } exp_t;

  dispatch_pipe #(
    .W_TAG (W_TAG),
    .W_DATA(W_DATA),
    .W_ADDR(W_ADDR),
    .N_EQ  (N_EQ)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ifq_inst        (ifq_inst),
    .ifq_pcout_plus4 (ifq_pcout_plus4),
    .ifq_empty       (ifq_empty),
    .ifq_ren         (ifq_ren),
    .ifq_branch_valid(ifq_branch_valid),
    .ifq_branch_addr (ifq_branch_addr),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .cdb_branch      (cdb_branch),
    .cdb_branch_taken(cdb_branch_taken),
    .tag_ren         (tag_ren),
    .tag_in          (tag_in),
    .tag_empty       (tag_empty),
    .rf_rsaddr       (rf_rsaddr),
    .rf_rtaddr       (rf_rtaddr),
    .rf_rsdata       (rf_rsdata),
    .rf_rtdata       (rf_rtdata),
    .rst_rsaddr      (rst_rsaddr),
    .rst_rtaddr      (rst_rtaddr),
    .rst_rstag       (rst_rstag),
    .rst_rttag       (rst_rttag),
    .rst_rspend      (rst_rspend),
    .rst_rtpend      (rst_rtpend),
    .rst_wen         (rst_wen),
    .rst_waddr       (rst_waddr),
    .rst_wtag        (rst_wtag),
    .eq_en           (eq_en),
    .eq_ready        (eq_ready),
    .eq_opcode       (eq_opcode),
    .eq_imm          (eq_imm),
    .eq_rdtag        (eq_rdtag),
    .eq_rstag        (eq_rstag),
    .eq_rttag        (eq_rttag),
    .eq_rsdata       (eq_rsdata),
    .eq_rtdata       (eq_rtdata),
    .eq_rsvalid      (eq_rsvalid),
    .eq_rtvalid      (eq_rtvalid),
    .perf_dispatched (perf_dispatched),
    .perf_stalls     (perf_stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference classification straight from the instruction-class rules.
  function automatic bit classify(input logic [31:0] ins, output exp_t e);
    bit known;
    e     = '0;
    e.imm = ins[15:0];
    known = 1'b1;
    case (ins[31:26])
      6'h00: begin
        e.opc  = ins[5:0];
        e.ch   = (ins[5:0] == 6'h18) ? 2'd2 : (ins[5:0] == 6'h1A) ? 2'd3 : 2'd1;
        e.dest = ins[15:11];
        e.wr   = (ins[15:11] != 5'd0);
      end
      6'h23: begin
        e.opc = 6'h23; e.ch = 2'd0; e.dest = ins[20:16]; e.wr = (ins[20:16] != 5'd0); e.lw = 1'b1;
      end
      6'h2B: begin
        e.opc = 6'h2B; e.ch = 2'd0;
      end
      default: known = 1'b0;
    endcase
    return known;
  endfunction

  task automatic reset_dut();
    reset = 1'b1; ifq_empty = 1'b1; ifq_inst = '0; ifq_pcout_plus4 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    tag_in = '0; tag_empty = 1'b0; rf_rsdata = '0; rf_rtdata = '0;
    rst_rstag = '0; rst_rttag = '0; rst_rspend = 1'b0; rst_rtpend = 1'b0; eq_ready = '1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    reset = 1'b1; ifq_empty = 1'b0; ifq_inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ifq_ren, tag_ren, rst_wen, ifq_branch_valid} !== 4'b0000 || eq_en !== 4'b0000)
      begin n_fail++; $display("FAIL reset_strobes: ren/tag/wen/br=%b eq_en=%b want 0",
        {ifq_ren, tag_ren, rst_wen, ifq_branch_valid}, eq_en); end
    n_checks++;
    if (ifq_branch_addr !== 32'h0)
      begin n_fail++; $display("FAIL reset_braddr: got %h want 0", ifq_branch_addr); end
    @(posedge clk); #1;
    reset = 1'b0; ifq_empty = 1'b1;
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0000 || tag_ren !== 1'b0)
      begin n_fail++; $display("FAIL reset_dv_invalid: eq_en=%b tag_ren=%b want 0", eq_en, tag_ren); end
    n_checks++;
    if (perf_dispatched !== 32'd0 || perf_stalls !== 32'd0)
      begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_dispatched, perf_stalls); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    reset_dut();
    ifq_inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20); ifq_pcout_plus4 = 32'h4; ifq_empty = 1'b0;
    tag_in = 6'd5; rf_rsdata = 32'h11; rf_rtdata = 32'h22;
    @(negedge clk);
    n_checks++;
    if (ifq_ren !== 1'b1 || eq_en !== 4'b0000)
      begin n_fail++; $display("FAIL add_load: ifq_ren=%b eq_en=%b want 1/0000", ifq_ren, eq_en); end
    @(posedge clk); #1;
    ifq_empty = 1'b1;
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0010 || tag_ren !== 1'b1 || eq_rdtag !== 6'd5)
      begin n_fail++; $display("FAIL add_issue: eq_en=%b tag_ren=%b rdtag=%0d want 0010/1/5",
        eq_en, tag_ren, eq_rdtag); end
    n_checks++;
    if (rst_wen !== 1'b1 || rst_waddr !== 5'd3 || rst_wtag !== 6'd5)
      begin n_fail++; $display("FAIL add_rst: wen=%b waddr=%0d wtag=%0d want 1/3/5",
        rst_wen, rst_waddr, rst_wtag); end
    n_checks++;
    if (eq_rsvalid !== 1'b1 || eq_rtvalid !== 1'b1 || eq_rsdata !== 32'h11 || eq_rtdata !== 32'h22)
      begin n_fail++; $display("FAIL add_operands: v=%b%b d=%h/%h want 11 11/22",
        eq_rsvalid, eq_rtvalid, eq_rsdata, eq_rtdata); end
    n_checks++;
    if (eq_opcode !== 6'h20 || rf_rsaddr !== 5'd1 || rf_rtaddr !== 5'd2 ||
        rst_rsaddr !== 5'd1 || rst_rtaddr !== 5'd2)
      begin n_fail++; $display("FAIL add_addr: opc=%h rs=%0d rt=%0d rsts=%0d rstt=%0d want 20/1/2/1/2",
        eq_opcode, rf_rsaddr, rf_rtaddr, rst_rsaddr, rst_rtaddr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0000)
      begin n_fail++; $display("FAIL add_no_dup: eq_en=%b want 0000", eq_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    reset_dut();
    ifq_inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20); ifq_empty = 1'b0;
    @(posedge clk); #1;
    ifq_empty = 1'b1; rf_rsdata = 32'h11;
    rst_rspend = 1'b1; rst_rstag = 6'd7; rst_rtpend = 1'b1; rst_rttag = 6'd20;
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hDEAD;
    @(negedge clk);
    n_checks++;
    if (eq_rsvalid !== 1'b1 || eq_rsdata !== 32'hDEAD)
      begin n_fail++; $display("FAIL fwd_hit: rsvalid=%b rsdata=%h want 1/dead", eq_rsvalid, eq_rsdata); end
    n_checks++;
    if (eq_rtvalid !== 1'b0)
      begin n_fail++; $display("FAIL fwd_rt_pending: rtvalid=%b want 0", eq_rtvalid); end
    cdb_tag = 6'd8;
    #1;
    n_checks++;
    if (eq_rsvalid !== 1'b0 || eq_rsdata !== 32'h11)
      begin n_fail++; $display("FAIL fwd_miss: rsvalid=%b rsdata=%h want 0/11", eq_rsvalid, eq_rsdata); end
    @(posedge clk); #1;
    cdb_valid = 1'b0;
  endtask

  task automatic test_lw_and_drop();
    reset_dut();
    ifq_inst = enc_i(6'h23, 5'd4, 5'd9, 16'h0010); ifq_empty = 1'b0; rst_rtpend = 1'b1;
    @(posedge clk); #1;
    ifq_inst = enc_i(6'h3F, 5'd1, 5'd1, 16'h0);
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0001 || rst_wen !== 1'b1 || rst_waddr !== 5'd9 || eq_rtvalid !== 1'b1 ||
        eq_imm !== 16'h0010)
      begin n_fail++; $display("FAIL lw_issue: en=%b wen=%b waddr=%0d rtv=%b imm=%h want 0001/1/9/1/0010",
        eq_en, rst_wen, rst_waddr, eq_rtvalid, eq_imm); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0000 || tag_ren !== 1'b0 || ifq_ren !== 1'b0)
      begin n_fail++; $display("FAIL drop_unknown: en=%b tag_ren=%b ifq_ren=%b want 0000/0/0",
        eq_en, tag_ren, ifq_ren); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (ifq_ren !== 1'b1)
      begin n_fail++; $display("FAIL drop_cleared: ifq_ren=%b want 1", ifq_ren); end
    @(posedge clk); #1;
    ifq_empty = 1'b1; rst_rtpend = 1'b0;
  endtask

  task automatic test_branch(input bit taken);
    reset_dut();
    ifq_inst = enc_i(6'h04, 5'd1, 5'd2, 16'd4); ifq_pcout_plus4 = 32'h100; ifq_empty = 1'b0;
    tag_in = 6'd9;
    @(posedge clk); #1;
    ifq_inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20); ifq_pcout_plus4 = 32'h104;
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0010 || eq_opcode !== 6'h04 || rst_wen !== 1'b0 || tag_ren !== 1'b1)
      begin n_fail++; $display("FAIL br_issue: en=%b opc=%h wen=%b tag_ren=%b want 0010/04/0/1",
        eq_en, eq_opcode, rst_wen, tag_ren); end
    @(posedge clk); #1;
    ifq_inst = enc_r(5'd4, 5'd5, 5'd6, 6'h22); tag_in = 6'd10;
    cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_tag = 6'd3; cdb_branch_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (eq_en !== 4'b0000 || ifq_ren !== 1'b0 || ifq_branch_valid !== 1'b0 || tag_ren !== 1'b0)
      begin n_fail++; $display("FAIL br_stall_other_tag: en=%b ren=%b brv=%b tag_ren=%b want 0",
        eq_en, ifq_ren, ifq_branch_valid, tag_ren); end
    @(posedge clk); #1;
    cdb_tag = 6'd9; cdb_branch_taken = taken;
    @(negedge clk);
    n_checks++;
    if (ifq_branch_valid !== taken || ifq_branch_addr !== (taken ? 32'h110 : 32'h0) ||
        ifq_ren !== 1'b0 || eq_en !== 4'b0000)
      begin n_fail++; $display("FAIL br_resolve(taken=%0d): brv=%b addr=%h ren=%b en=%b want %0d/%h/0/0000",
        taken, ifq_branch_valid, ifq_branch_addr, ifq_ren, eq_en, taken, taken ? 32'h110 : 32'h0); end
    @(posedge clk); #1;
    cdb_valid = 1'b0; cdb_branch = 1'b0; ifq_empty = 1'b1;
    @(negedge clk);
    n_checks++;
    if (eq_en !== (taken ? 4'b0000 : 4'b0010) || ifq_branch_valid !== 1'b0 || ifq_branch_addr !== 32'h0)
      begin n_fail++; $display("FAIL br_after(taken=%0d): en=%b brv=%b addr=%h want %b/0/0",
        taken, eq_en, ifq_branch_valid, ifq_branch_addr, taken ? 4'b0000 : 4'b0010); end
    if (!taken) begin
      n_checks++;
      if (rst_waddr !== 5'd3 || eq_rdtag !== 6'd10)
        begin n_fail++; $display("FAIL br_held_add: waddr=%0d rdtag=%0d want 3/10", rst_waddr, eq_rdtag); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    ifq_inst = enc_i(6'h05, 5'd1, 5'd2, 16'd4); ifq_pcout_plus4 = 32'h100; ifq_empty = 1'b0;
    tag_in = 6'd9;
    @(posedge clk); #1;
    ifq_empty = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_tag = 6'd9; cdb_branch_taken = 1'b1;
    ifq_inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20); ifq_empty = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifq_branch_valid !== 1'b0 || ifq_ren !== 1'b1)
      begin n_fail++; $display("FAIL reset_mid_stall: brv=%b ren=%b want 0/1", ifq_branch_valid, ifq_ren); end
    @(posedge clk); #1;
    cdb_valid = 1'b0; cdb_branch = 1'b0; ifq_empty = 1'b1;
  endtask

  task automatic test_jump();
    reset_dut();
    ifq_inst = {6'h02, 26'h0000040}; ifq_pcout_plus4 = 32'h10000004; ifq_empty = 1'b0;
    @(posedge clk); #1;
    ifq_inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20); ifq_pcout_plus4 = 32'h10000008;
    @(negedge clk);
    n_checks++;
    if (ifq_branch_valid !== 1'b1 || ifq_branch_addr !== 32'h10000100 || ifq_ren !== 1'b0 ||
        eq_en !== 4'b0000 || tag_ren !== 1'b0)
      begin n_fail++; $display("FAIL jump: brv=%b addr=%h ren=%b en=%b tag_ren=%b want 1/10000100/0/0000/0",
        ifq_branch_valid, ifq_branch_addr, ifq_ren, eq_en, tag_ren); end
    @(posedge clk); #1;
    ifq_empty = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ifq_branch_valid !== 1'b0 || ifq_branch_addr !== 32'h0 || eq_en !== 4'b0000)
      begin n_fail++; $display("FAIL jump_one_shot: brv=%b addr=%h en=%b want 0/0/0000",
        ifq_branch_valid, ifq_branch_addr, eq_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_ready();
    int en2_stall = 0;
    int en2_total = 0;
    int tags      = 0;
    reset_dut();
    eq_ready = 4'b1011; ifq_inst = enc_r(5'd1, 5'd2, 5'd4, 6'h18); ifq_empty = 1'b0; tag_in = 6'd12;
    @(posedge clk); #1;
    ifq_empty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) eq_ready = 4'b1111;
      @(negedge clk);
      if (eq_en[2]) begin en2_total++; if (i < 3) en2_stall++; end
      if (tag_ren) tags++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (en2_stall != 0 || en2_total != 1 || tags != 1)
      begin n_fail++; $display("FAIL mult_hold: stall_pulses=%0d pulses=%0d tags=%0d want 0/1/1",
        en2_stall, en2_total, tags); end
`ifdef DISPATCH_PERF_CNT_EN
    n_checks++;
    if (perf_stalls !== 32'd3 || perf_dispatched !== 32'd1)
      begin n_fail++; $display("FAIL mult_perf: stalls=%0d disp=%0d want 3/1", perf_stalls, perf_dispatched); end
`else
    n_checks++;
    if (perf_stalls !== 32'd0 || perf_dispatched !== 32'd0)
      begin n_fail++; $display("FAIL mult_perf_off: stalls=%0d disp=%0d want 0/0", perf_stalls, perf_dispatched); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] prog[$];
    exp_t        expq[$];
    exp_t        e;
    bit          held_unknown = 1'b0;
    bit          dv_m, fire_m, ren_m, rs_hit, rt_hit;
    logic [3:0]  en_m;
    int          head = 0;
    int          n    = 80;
    for (int i = 0; i < n; i++) begin
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: prog.push_back(enc_r(rs, rt, rd, 6'h20 + 6'($urandom_range(0, 10))));
        1: prog.push_back(enc_r(rs, rt, rd, 6'h18));
        2: prog.push_back(enc_r(rs, rt, rd, 6'h1A));
        3: prog.push_back(enc_i(6'h23, rs, rt, 16'($urandom)));
        4: prog.push_back(enc_i(6'h2B, rs, rt, 16'($urandom)));
        default: prog.push_back(enc_i(6'h3C + 6'($urandom_range(0, 3)), rs, rt, 16'($urandom)));
      endcase
    end
    reset_dut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (head >= n && expq.size() == 0 && !held_unknown) break;
      ifq_empty       = (head >= n) || ($urandom_range(0, 3) == 0);
      ifq_inst        = (head < n) ? prog[head] : 32'h0;
      ifq_pcout_plus4 = $urandom;
      eq_ready        = 4'($urandom) | 4'($urandom);
      tag_empty       = ($urandom_range(0, 4) == 0);
      tag_in          = W_TAG'($urandom);
      rst_rspend = 1'($urandom); rst_rstag = W_TAG'($urandom);
      rst_rtpend = 1'($urandom); rst_rttag = W_TAG'($urandom);
      cdb_valid  = 1'($urandom); cdb_data = $urandom;
      case ($urandom_range(0, 2))
        0: cdb_tag = rst_rstag;
        1: cdb_tag = rst_rttag;
        default: cdb_tag = W_TAG'($urandom);
      endcase
      rf_rsdata = $urandom; rf_rtdata = $urandom;
      @(negedge clk);
      dv_m   = (expq.size() > 0) || held_unknown;
      fire_m = 1'b0;
      if (expq.size() > 0) fire_m = eq_ready[expq[0].ch] && !tag_empty;
      ren_m  = !ifq_empty && (!dv_m || fire_m);
      en_m   = 4'b0000;
      if (fire_m) en_m[expq[0].ch] = 1'b1;
      n_checks++;
      if (ifq_ren !== ren_m || eq_en !== en_m || tag_ren !== fire_m || ifq_branch_valid !== 1'b0)
        begin n_fail++; $display("FAIL rnd_ctrl cyc %0d: ren=%b en=%b tag_ren=%b brv=%b want %b/%b/%b/0",
          cyc, ifq_ren, eq_en, tag_ren, ifq_branch_valid, ren_m, en_m, fire_m); end
      if (fire_m) begin
        e      = expq[0];
        rs_hit = cdb_valid && (cdb_tag == rst_rstag);
        rt_hit = cdb_valid && (cdb_tag == rst_rttag);
        n_checks++;
        if (eq_rdtag !== tag_in || eq_opcode !== e.opc || eq_imm !== e.imm || rst_wen !== e.wr ||
            (e.wr && rst_waddr !== e.dest))
          begin n_fail++; $display("FAIL rnd_issue cyc %0d: tag=%0d opc=%h imm=%h wen=%b waddr=%0d want %0d/%h/%h/%b/%0d",
            cyc, eq_rdtag, eq_opcode, eq_imm, rst_wen, rst_waddr, tag_in, e.opc, e.imm, e.wr, e.dest); end
        n_checks++;
        if (eq_rsvalid !== (!rst_rspend || rs_hit) || eq_rsdata !== (rs_hit ? cdb_data : rf_rsdata) ||
            eq_rtvalid !== (e.lw || !rst_rtpend || rt_hit) ||
            eq_rtdata !== (rt_hit ? cdb_data : rf_rtdata) ||
            eq_rstag !== rst_rstag || eq_rttag !== rst_rttag)
          begin n_fail++; $display("FAIL rnd_operands cyc %0d: rsv=%b rs=%h rtv=%b rt=%h", cyc,
            eq_rsvalid, eq_rsdata, eq_rtvalid, eq_rtdata); end
      end else begin
        n_checks++;
        if (rst_wen !== 1'b0)
          begin n_fail++; $display("FAIL rnd_idle_wen cyc %0d: wen=%b want 0", cyc, rst_wen); end
      end
      held_unknown = 1'b0;
      if (fire_m) void'(expq.pop_front());
      if (ren_m) begin
        if (classify(prog[head], e)) expq.push_back(e);
        else held_unknown = 1'b1;
        head++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (head != n || expq.size() != 0 || held_unknown)
      begin n_fail++; $display("FAIL rnd_drain: consumed=%0d pending=%0d want %0d/0", head, expq.size(), n); end
    ifq_empty = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_lw_and_drop();
    test_branch(1'b1);
    test_branch(1'b0);
    test_reset_mid_stall();
    test_jump();
    test_back_to_back_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_pipe.md
Name: dispatch_pipe

Overview:
Next-generation Tomasulo dispatch stage. It adds a one-entry decode register between the IFQ and issue, and takes parametrised tag, data and register-address widths. It drives N_EQ issue-queue channels through a one-hot enable vector. Branch resolution is tag-matched on the CDB; the stage stalls only on its own branch, not on any CDB branch. Regfile, register status table (RST) and tag FIFO sit outside the block and are reached through ports.

Parameters:
W_TAG, 6, tag width (tag FIFO / RST / CDB)
W_DATA, 32, operand data width
W_ADDR, 5, architectural register address width
N_EQ, 4, issue-queue channels; index 0=LS, 1=INT, 2=MULT, 3=DIV

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ifq_inst  in  32  instruction at IFQ head
ifq_pcout_plus4  in  32  PC+4 of head
ifq_empty  in  1  IFQ empty
ifq_ren  out  1  pop IFQ
ifq_branch_valid  out  1  one-cycle redirect pulse
ifq_branch_addr  out  32  redirect target
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  W_TAG  CDB tag
cdb_data  in  W_DATA  CDB data
cdb_branch  in  1  broadcast is a branch result
cdb_branch_taken  in  1  branch outcome
tag_ren  out  1  consume tag from tag FIFO
tag_in  in  W_TAG  free tag at FIFO head
tag_empty  in  1  tag FIFO empty
rf_rsaddr, rf_rtaddr  out  W_ADDR  regfile read addresses
rf_rsdata, rf_rtdata  in  W_DATA  regfile read data
rst_rsaddr, rst_rtaddr  out  W_ADDR  RST lookup addresses
rst_rstag, rst_rttag  in  W_TAG  pending producer tags
rst_rspend, rst_rtpend  in  1  register awaiting producer
rst_wen  out  1  RST write enable
rst_waddr  out  W_ADDR  RST destination register
rst_wtag  out  W_TAG  tag written to RST
eq_en  out  N_EQ  one-hot issue enable
eq_ready  in  N_EQ  per-channel ready
eq_opcode  out  6  func (R-type) or opcode
eq_imm  out  16  immediate
eq_rdtag, eq_rstag, eq_rttag  out  W_TAG  destination and source tags
eq_rsdata, eq_rtdata  out  W_DATA  operand data
eq_rsvalid, eq_rtvalid  out  1  operand data valid
perf_dispatched, perf_stalls  out  32  counters (optional feature)

Behaviour:
- Reset (synchronous, active-high): state=S_DISPATCH; decode reg invalid; br_tag=0; br_target=0. All outputs combinationally 0: ifq_ren, eq_en, tag_ren, rst_wen, ifq_branch_valid. Reset mid-stall abandons the pending branch.
- Decode reg (dv, inst, pc4): loads when ifq_ren=1. ifq_ren = ~ifq_empty & (~dv | fire) & state==S_DISPATCH & ~jump_now. IFQ-to-issue latency is 1 cycle minimum.
- Classes, all read from the decode reg:
  - R-type MULT → ch2; DIV → ch3; other funct → ch1, eq_opcode=func.
  - BEQ/BNE → ch1, eq_opcode=opcode.
  - LW/SW → ch0.
  - J → no channel.
  - Unknown opcode → dropped: dv cleared, nothing issued.
- Tags: every class except J and unknown needs a tag.
- fire = dv & state==S_DISPATCH & eq_ready[ch] & ~tag_empty. On fire: eq_en[ch]=1, tag_ren=1, eq_rdtag=tag_in.
- RST write: rst_wen=fire for R-type (rst_waddr=rd) and LW (rst_waddr=rt). Destination register 0 gives rst_wen=0, but the tag is still consumed. SW and branches never write the RST.
- Operands:
  - rsvalid = ~rst_rspend | (cdb_valid & cdb_tag==rst_rstag).
  - rsdata = CDB data when that forward hits, else rf_rsdata. Same rule for rt.
  - LW forces rtvalid=1.
- J: when dv holds J, jump_now=1. ifq_branch_valid=1 for one cycle with addr = {pc4[31:28], inst[25:0], 2'b00}. dv cleared. ifq_ren=0 that cycle (IFQ flushes on redirect).
- Branch FSM, state S_DISPATCH → S_BRSTALL on branch fire:
  - Latch br_tag=tag_in and br_target = pc4 + sext(imm)<<2 (mod 2^32).
  - In S_BRSTALL: no fire, ifq_ren=0. The decode reg may hold the fall-through instruction.
  - Exit on cdb_valid & cdb_branch & cdb_tag==br_tag. A non-matching CDB branch is ignored.
  - Taken: ifq_branch_valid=1, addr=br_target, dv cleared, → S_DISPATCH.
  - Not taken: → S_DISPATCH; the held instruction may fire the next cycle.
- ifq_branch_addr is 0 whenever ifq_branch_valid=0.
- Ready or tag-FIFO deassertion holds the decode reg unchanged (no loss, no duplicate).

Optional Feature:
DISPATCH_PERF_CNT_EN: when defined, perf_dispatched increments on each fire, wrapping at 2^32. perf_stalls increments each cycle with dv=1 and no fire (including S_BRSTALL). Both reset to 0. When undefined, both ports are tied to 0 and the counter flops are not present.

Decomposition:
- Opcode/funct constants: existing shared header.
- New constants EQ_LS=0, EQ_INT=1, EQ_MULT=2, EQ_DIV=3 and the FSM state encodings go in the shared globals header.
- One natural sub-module: dispatch_decode, purely combinational, decode-reg instruction → channel index, needs_tag, writes_rst, dest address, is_branch, is_jump, eq_opcode.

Test Plan:
- ADD r3,r1,r2, all regs ready, tag_in=5 → next cycle eq_en=4'b0010, eq_rdtag=5, rst_wen=1, rst_waddr=3, rsvalid=rtvalid=1.
- rst_rspend=1, rst_rstag=7, same-cycle CDB tag 7 data 0xDEAD → eq_rsvalid=1, eq_rsdata=0xDEAD.
- BEQ at pc4=0x100, imm=4, tag 9; unrelated CDB branch tag 3 → remains S_BRSTALL. CDB tag 9 taken → ifq_branch_valid=1, addr=0x110, held instruction discarded.
- Same BEQ not taken → no redirect; the held ADD fires the cycle after resolution.
- J 0x0000040 with pc4=0x10000004 → one-cycle ifq_branch_valid, addr=0x10000100, ifq_ren=0 that cycle.
- eq_ready[2]=0 with MULT held 3 cycles, then 1 → exactly one eq_en[2] pulse, one tag_ren. With DISPATCH_PERF_CNT_EN: perf_stalls=3, perf_dispatched=1.
